booth_ppg: RTL and testbench

- Radix-4 (modified Booth) partial-product generator for an 8x8 signed multiplier, feeding the MAC's partial-product compressor tree.
- Encodes the multiplier into 4 Booth digits and emits 4 partial products, each with sign-extension elimination and a separate negate (+1) bit.
- Downstream sums: pp0 + pp1<<2 + pp2<<4 + pp3<<6 + neg0 + neg1<<2 + neg2<<4 + neg3<<6 + 17'h15000.
- Modulo 2^17, this sum equals the signed product sign-extended to 17 bits.
- Outputs are registered, giving one cycle of latency.

---
 rtl/booth_pkg.sv | 15 +
 rtl/booth_row.sv | 21 ++
 rtl/booth_ppg.sv | 58 +++++
 tb/tb_booth_ppg.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: Booth triplet codes, row geometry and the compressor compensation constant
package booth_pkg;
    localparam int ROWS  = 4;
    localparam int ROW_W = 9;
    // Constant the compressor adds to undo the sign-extension-elimination encoding
    localparam logic [16:0] COMP = 17'h15000;
    localparam logic [2:0] TRIP_Z0  = 3'b000;
    localparam logic [2:0] TRIP_P1A = 3'b001;
    localparam logic [2:0] TRIP_P1B = 3'b010;
    localparam logic [2:0] TRIP_P2  = 3'b011;
    localparam logic [2:0] TRIP_N2  = 3'b100;
    localparam logic [2:0] TRIP_N1A = 3'b101;
    localparam logic [2:0] TRIP_N1B = 3'b110;
    localparam logic [2:0] TRIP_Z1  = 3'b111;
endpackage

// File: rtl/booth_row.sv
// booth_row: one radix-4 Booth row; trip/m in, ones-complement row p and negate bit out
module booth_row
    import booth_pkg::*;
(
    input  logic [2:0]       trip,
    input  logic [7:0]       m,
    output logic [ROW_W-1:0] p,
    output logic             neg
);
    logic             one;
    logic             two;
    logic [ROW_W-1:0] a;
    always_comb begin
        one = trip == TRIP_P1A || trip == TRIP_P1B || trip == TRIP_N1A || trip == TRIP_N1B;
        two = trip == TRIP_P2 || trip == TRIP_N2;
        // 111 is a zero digit, so it must not invert
        neg = trip[2] && trip != TRIP_Z1;
        a   = two ? {m, 1'b0} : one ? {m[7], m} : '0;
        p   = neg ? ~a : a;
    end
endmodule

// File: rtl/booth_ppg.sv
// booth_ppg: registered radix-4 Booth partial-product generator for an 8x8 signed multiply
//   in:  clk, reset (async active-low), in_valid, multiplicand, multiplier
//   out: out_valid, pp0 (12b), pp1..pp3 (10b), neg0..neg3
module booth_ppg
    import booth_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] multiplicand,
    input  logic [7:0] multiplier,
    output logic       out_valid,
    output logic [11:0] pp0,
    output logic [9:0] pp1,
    output logic [9:0] pp2,
    output logic [9:0] pp3,
    output logic       neg0,
    output logic       neg1,
    output logic       neg2,
    output logic       neg3
);
    logic [9:0]       yx;
    logic [ROW_W-1:0] p [ROWS];
    logic [ROWS-1:0]  n;

    // Appended zero supplies Y[-1] for the first triplet
    assign yx = {multiplier, 1'b0};

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        booth_row u_row (
            .trip (yx[2*i+2:2*i]),
            .m    (multiplicand),
            .p    (p[i]),
            .neg  (n[i])
        );
    end

    // Sign-extension elimination: row 0 gets {~s,s,s}, higher rows {~s}
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            pp0       <= '0;
            pp1       <= '0;
            pp2       <= '0;
            pp3       <= '0;
            {neg3, neg2, neg1, neg0} <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                pp0 <= {~p[0][8], p[0][8], p[0][8], p[0]};
                pp1 <= {~p[1][8], p[1]};
                pp2 <= {~p[2][8], p[2]};
                pp3 <= {~p[3][8], p[3]};
                {neg3, neg2, neg1, neg0} <= n;
            end
        end
    end
endmodule

// File: tb/tb_booth_ppg.sv
// tb_booth_ppg: scoreboard bench for booth_ppg with directed vectors and an operand sweep
module tb_booth_ppg;
    typedef struct {
        logic [7:0]  m;
        logic [7:0]  y;
        logic        chk;
        logic [11:0] e0;
        logic [9:0]  e1;
        logic [9:0]  e2;
        logic [9:0]  e3;
        logic [3:0]  en;
        logic [16:0] ep;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        out_valid;
    logic [11:0] pp0;
    logic [9:0]  pp1;
    logic [9:0]  pp2;
    logic [9:0]  pp3;
    logic        neg0;
    logic        neg1;
    logic        neg2;
    logic        neg3;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q [$];

    booth_ppg dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .pp0          (pp0),
        .pp1          (pp1),
        .pp2          (pp2),
        .pp3          (pp3),
        .neg0         (neg0),
        .neg1         (neg1),
        .neg2         (neg2),
        .neg3         (neg3)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic chk,
                         input logic [11:0] e0, input logic [9:0] e1, input logic [9:0] e2,
                         input logic [9:0] e3, input logic [3:0] en, input logic [16:0] ep);
        exp_t e;
        @(negedge clk);
        in_valid     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        e = '{a, b, chk, e0, e1, e2, e3, en, ep};
        q.push_back(e);
    endtask

    task automatic check_zero(input string name);
        cmp(name, {17'h0, out_valid, pp0, pp1, pp2, pp3, neg3, neg2, neg1, neg0}, 64'h0);
    endtask

    // Monitor: pops one expectation per valid output and checks the weighted sum
    always @(negedge clk) begin
        exp_t        e;
        logic [16:0] s;
        if (out_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got out_valid=1, required no pending result");
            end else begin
                e = q.pop_front();
                s = 17'(pp0) + (17'(pp1) << 2) + (17'(pp2) << 4) + (17'(pp3) << 6)
                  + 17'(neg0) + (17'(neg1) << 2) + (17'(neg2) << 4) + (17'(neg3) << 6)
                  + 17'h15000;
                n_cmp++;
                if (s !== e.ep) begin
                    n_bad++;
                    $display("FAIL product M=%h Y=%h: got %h, required %h", e.m, e.y, s, e.ep);
                end
                if (e.chk)
                    cmp("fields", {pp0, pp1, pp2, pp3, neg3, neg2, neg1, neg0},
                        {e.e0, e.e1, e.e2, e.e3, e.en});
            end
        end
    end

    initial begin
        int pr;
        reset        = 1'b0;
        in_valid     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(negedge clk);
        check_zero("reset_init");
        reset = 1'b1;
        // Directed vectors: M, Y, fields, {neg3..neg0}, 17-bit product
        issue(8'h00, 8'h00, 1'b1, 12'h800, 10'h200, 10'h200, 10'h200, 4'b0000, 17'h00000);
        issue(8'hFF, 8'h03, 1'b1, 12'h800, 10'h1FF, 10'h200, 10'h200, 4'b0001, 17'h1FFFD);
        issue(8'h01, 8'h01, 1'b1, 12'h801, 10'h200, 10'h200, 10'h200, 4'b0000, 17'h00001);
        issue(8'h05, 8'hFF, 1'b1, 12'h7FA, 10'h200, 10'h200, 10'h200, 4'b0001, 17'h1FFFB);
        issue(8'h7F, 8'h80, 1'b1, 12'h800, 10'h200, 10'h200, 10'h101, 4'b1000, 17'h1C080);
        issue(8'h80, 8'h80, 1'b1, 12'h800, 10'h200, 10'h200, 10'h2FF, 4'b1000, 17'h04000);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        cmp("hold_valid", 64'(out_valid), 64'h0);
        cmp("hold_data", {pp3, neg3}, {10'h2FF, 1'b1});
        // Reset mid-operation discards the captured result
        issue(8'h12, 8'h34, 1'b0, '0, '0, '0, '0, '0, 17'h003A8);
        @(posedge clk);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_zero("reset_async");
        q.delete();
        repeat (2) @(negedge clk);
        check_zero("reset_held");
        reset = 1'b1;
        issue(8'h03, 8'h02, 1'b0, '0, '0, '0, '0, '0, 17'h00006);
        @(negedge clk);
        cmp("latency1", 64'(out_valid), 64'h1);
        in_valid = 1'b0;
        // Full operand sweep, back to back
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                pr = int'($signed(8'(a))) * int'($signed(8'(b)));
                issue(8'(a), 8'(b), 1'b0, '0, '0, '0, '0, '0, pr[16:0]);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        cmp("drain", 64'(q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
